// File: rtl/spi_slave_pkg.sv
`default_nettype none
// ---- RAM_shared_pkg / spi_shared_pkg: shared widths, command codes, FSM states -- rev 1.0 ----
package RAM_shared_pkg;
   localparam int         ADDR_SIZE   = 8;
   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;
endpackage

package spi_shared_pkg;
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_e;
endpackage
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// ---- spi_slave_if: SPI pins plus RAM-side rx/tx handshake -- rev 1.0 ----
interface spi_slave_if #(
   parameter int ADDR_SIZE = RAM_shared_pkg::ADDR_SIZE
);
   logic                 SS_n;
   logic                 MOSI;
   logic                 MISO;
   logic                 tx_valid;
   logic [ADDR_SIZE-1:0] tx_data;
   logic                 rx_valid;
   logic [ADDR_SIZE+1:0] rx_data;

   modport slave  (input  SS_n, MOSI, tx_valid, tx_data, output MISO, rx_valid, rx_data);
   modport master (output SS_n, MOSI, tx_valid, tx_data, input  MISO, rx_valid, rx_data);
endinterface
`default_nettype wire

// File: rtl/spi_slave_tx_serializer.sv
`default_nettype none
// ---- spi_tx_serializer: loads a RAM byte and shifts it out MSB first, one bit per cycle -- rev 1.0 ----
module spi_tx_serializer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear_i,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   output logic         miso_o
);
   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  shreg_q, shreg_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          miso_q, miso_d;

   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      miso_d  = 1'b0;
      if (clear_i) begin
         shreg_d = '0;
         cnt_d   = '0;
      end else if (load_i) begin
         shreg_d = data_i;
         cnt_d   = CW'(W);
      end else if (cnt_q != '0) begin
         miso_d  = shreg_q[W-1];
         shreg_d = {shreg_q[W-2:0], 1'b0};
         cnt_d   = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg_q <= '0;
         cnt_q   <= '0;
         miso_q  <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         miso_q  <= miso_d;
      end
   end

   assign miso_o = miso_q;
endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ---- spi_slave: deserialises 10-bit MOSI frames for the RAM and returns read data on MISO -- rev 1.0 ----
module spi_slave
   import RAM_shared_pkg::*;
   import spi_shared_pkg::*;
#(
   parameter int ADDR_SIZE = RAM_shared_pkg::ADDR_SIZE
) (
   input logic       clk,
   input logic       rst,
   spi_slave_if.slave bus
);
   localparam int            FW       = ADDR_SIZE + 2;
   localparam int            CW       = $clog2(FW + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FW - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(FW);

   state_e         state_q, state_d;
   logic [FW-2:0]  shift_q, shift_d;
   logic [FW-1:0]  rx_data_q, rx_data_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           rx_valid_q, rx_valid_d;
   logic           rd_addr_q, rd_addr_d;
   logic           tx_wait_q, tx_wait_d;
   logic           tx_load, tx_clear;
   logic           miso_w;
   logic [FW-1:0]  frame_w;

   assign frame_w = {shift_q, bus.MOSI};

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      rx_data_d  = rx_data_q;
      cnt_d      = cnt_q;
      rx_valid_d = 1'b0;
      rd_addr_d  = rd_addr_q;
      tx_wait_d  = tx_wait_q;
      tx_load    = 1'b0;
      tx_clear   = 1'b0;
      if (bus.SS_n) begin
         state_d   = IDLE;
         cnt_d     = '0;
         tx_wait_d = 1'b0;
         tx_clear  = 1'b1;
      end else begin
         case (state_q)
            IDLE: state_d = CHK_CMD;
            CHK_CMD: begin
               shift_d = frame_w[FW-2:0];
               cnt_d   = CW'(1);
               if (!bus.MOSI)     state_d = WRITE;
               else if (rd_addr_q) state_d = READ_DATA;
               else               state_d = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
               if (cnt_q < CNT_FULL) begin
                  shift_d = frame_w[FW-2:0];
                  cnt_d   = cnt_q + CW'(1);
                  if (cnt_q == CNT_LAST) begin
                     rx_data_d  = frame_w;
                     rx_valid_d = 1'b1;
                     if (frame_w[FW-1 -: 2] == CMD_RD_ADDR)      rd_addr_d = 1'b1;
                     else if (frame_w[FW-1 -: 2] == CMD_RD_DATA) rd_addr_d = 1'b0;
                     tx_wait_d = (state_q == READ_DATA);
                  end
               end else if (tx_wait_q && bus.tx_valid) begin
                  // Only the first tx_valid sample after the frame is taken.
                  tx_load   = 1'b1;
                  tx_wait_d = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         rx_data_q  <= '0;
         cnt_q      <= '0;
         rx_valid_q <= 1'b0;
         rd_addr_q  <= 1'b0;
         tx_wait_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         rx_data_q  <= rx_data_d;
         cnt_q      <= cnt_d;
         rx_valid_q <= rx_valid_d;
         rd_addr_q  <= rd_addr_d;
         tx_wait_q  <= tx_wait_d;
      end
   end

   spi_tx_serializer #(.W(ADDR_SIZE)) u_tx (
      .clk    (clk),
      .rst    (rst),
      .clear_i(tx_clear),
      .load_i (tx_load),
      .data_i (bus.tx_data),
      .miso_o (miso_w)
   );

   assign bus.MISO     = miso_w;
   assign bus.rx_valid = rx_valid_q;
   assign bus.rx_data  = rx_data_q;
endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ---- tb_spi_slave: frame table, reset sequence and random frames against a frame-level model -- rev 1.0 ----
module tb_spi_slave;
   import spi_shared_pkg::*;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   bit   model_flag;

   spi_slave_if #(.ADDR_SIZE(8)) bus ();
   spi_slave #(.ADDR_SIZE(8)) dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] frame;
      int         nbits;
      int         extra;
      bit         give_tx;
      logic [7:0] txd;
      int         delay;
      int         rst_at;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input logic ss, input logic mosi, input logic txv, input logic [7:0] txd,
                       input logic exp_rxv, input logic [9:0] exp_rxd, input logic exp_miso,
                       input string tag);
      bus.SS_n     = ss;
      bus.MOSI     = mosi;
      bus.tx_valid = txv;
      bus.tx_data  = txd;
      @(posedge clk);
      #1;
      chk({tag, " rx_valid"}, 32'(bus.rx_valid), 32'(exp_rxv));
      chk({tag, " MISO"}, 32'(bus.MISO), 32'(exp_miso));
      if (exp_rxv) chk({tag, " rx_data"}, 32'(bus.rx_data), 32'(exp_rxd));
   endtask

   // Edge 0 sees SS_n low, edges 1..10 carry the frame, the RAM byte is
   // offered at edge t and must appear on MISO after edges t+1..t+8.
   task automatic run_frame(input vec_t v, input string tag);
      bit rd_path = v.frame[9] && model_flag;
      int t       = 11 + v.delay;
      int len     = (v.nbits < 10) ? 1 + v.nbits : 11 + v.extra;
      for (int e = 0; e < len; e++) begin
         logic       mosi;
         logic       txv;
         logic       emiso;
         logic [7:0] td;
         mosi = (e >= 1 && e <= v.nbits) ? v.frame[10-e] : 1'($urandom);
         td   = 8'($urandom);
         if (rd_path) begin
            if (!v.give_tx || e < t) txv = 1'b0;
            else if (e < t + 3)      txv = 1'b1;
            else                     txv = 1'($urandom);
            if (e == t) td = v.txd;
         end else begin
            txv = 1'($urandom);
         end
         emiso = (rd_path && v.give_tx && e > t && e <= t + 8) ? v.txd[7-(e-t-1)] : 1'b0;
         tick(1'b0, mosi, txv, td, (e == 10 && v.nbits == 10), v.frame, emiso,
              $sformatf("%s e%0d", tag, e));
         if (e == 10 && v.nbits == 10) begin
            if (v.frame[9:8] == 2'b10)      model_flag = 1'b1;
            else if (v.frame[9:8] == 2'b11) model_flag = 1'b0;
         end
         if (e == v.rst_at) begin
            #1 rst = 1'b1;
            #1;
            chk({tag, " async rst MISO"}, 32'(bus.MISO), 32'd0);
            chk({tag, " async rst rx_valid"}, 32'(bus.rx_valid), 32'd0);
            chk({tag, " async rst rx_data"}, 32'(bus.rx_data), 32'd0);
            chk({tag, " async rst state"}, 32'(dut.state_q), 32'(IDLE));
            rst        = 1'b0;
            model_flag = 1'b0;
            break;
         end
      end
      tick(1'b1, 1'($urandom), 1'b0, 8'h00, 1'b0, 10'h000, 1'b0, {tag, " ss_hi"});
   endtask

   initial begin
      vec_t tbl[9];
      tbl[0] = '{10'h005, 10, 3,  1'b0, 8'h00, 0, -1};  // write address
      tbl[1] = '{10'h1AA, 10, 3,  1'b0, 8'h00, 0, -1};  // write data
      tbl[2] = '{10'h205, 10, 3,  1'b0, 8'h00, 0, -1};  // read address, flag set
      tbl[3] = '{10'h3C3, 10, 12, 1'b1, 8'hA5, 0, -1};  // read data, MISO A5
      tbl[4] = '{10'h3FF, 10, 12, 1'b1, 8'h5A, 0, -1};  // flag now 0: READ_ADD, raw
      tbl[5] = '{10'h2AA, 6,  0,  1'b0, 8'h00, 0, -1};  // abort after 6 bits
      tbl[6] = '{10'h301, 10, 12, 1'b1, 8'h77, 1, -1};  // abort left flag at 0
      tbl[7] = '{10'h2F0, 10, 2,  1'b0, 8'h00, 0, -1};
      tbl[8] = '{10'h366, 10, 8,  1'b1, 8'h3C, 3, -1};  // SS_n rises mid-shift

      rst          = 1'b1;
      bus.SS_n     = 1'b1;
      bus.MOSI     = 1'b0;
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      model_flag   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset MISO", 32'(bus.MISO), 32'd0);
      chk("reset rx_valid", 32'(bus.rx_valid), 32'd0);
      chk("reset rx_data", 32'(bus.rx_data), 32'd0);
      chk("reset state", 32'(dut.state_q), 32'(IDLE));
      rst = 1'b0;
      tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 10'h000, 1'b0, "idle");

      for (int i = 0; i < 9; i++) run_frame(tbl[i], $sformatf("tbl%0d", i));

      run_frame('{10'h201, 10, 2,  1'b0, 8'h00, 0, -1}, "rst_ra");
      run_frame('{10'h3AB, 10, 12, 1'b1, 8'hFF, 0, 14}, "rst_rd");
      run_frame('{10'h1C3, 10, 3,  1'b0, 8'h00, 0, -1}, "post_rst");
      run_frame('{10'h3C3, 10, 12, 1'b1, 8'hFF, 0, -1}, "post_rst_rd");

      for (int i = 0; i < 40; i++) begin
         vec_t v;
         v.frame   = 10'($urandom);
         v.nbits   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 9)) : 10;
         v.give_tx = 1'b1;
         v.txd     = 8'($urandom);
         v.delay   = int'($urandom_range(0, 3));
         v.extra   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, v.delay + 8)) : v.delay + 12;
         v.rst_at  = -1;
         run_frame(v, $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
